// File: rtl/param_delay_line.sv
// Programmable-length sample delay (1..DEPTH accepted samples) built on a circular buffer.
// Optional sample counter output is enabled by defining PARAM_DELAY_LINE_COUNT_EN.
module param_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int DW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic [DW-1:0]    cfg_delay,
   input  logic             cfg_load,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             primed,
   output logic [DW-1:0]    delay_act
`ifdef PARAM_DELAY_LINE_COUNT_EN
   ,
   output logic [15:0]      smp_count
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {EMPTY, FILLING, PRIMED} state_t;

   function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
      if (d == '0)
         return DW'(1);
      else if (d > DW'(DEPTH))
         return DW'(DEPTH);
      else
         return d;
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];

   state_t        state, state_n;
   logic [AW-1:0] wr_ptr, wr_ptr_inc, rd_ptr;
   logic [DW-1:0] fill, fill_inc, fill_n, delay_n;
   logic [DW:0]   wp_ext, rd_ext;
   logic          valid_n;

   // Tap address (wr_ptr - D) mod DEPTH, done with an explicit wrap so
   // non-power-of-two depths stay correct.
   always_comb begin
      wp_ext = (DW+1)'(wr_ptr);
      if (wp_ext >= {1'b0, delay_act})
         rd_ext = wp_ext - {1'b0, delay_act};
      else
         rd_ext = wp_ext + (DW+1)'(DEPTH) - {1'b0, delay_act};
      rd_ptr = AW'(rd_ext);
   end

   assign wr_ptr_inc = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
   assign fill_inc   = (fill == DW'(DEPTH)) ? fill : fill + DW'(1);

   // A reload restarts the fill; a sample accepted alongside it is sample 0.
   always_comb begin
      delay_n = delay_act;
      fill_n  = fill;
      state_n = state;
      valid_n = 1'b0;
      if (cfg_load) begin
         delay_n = clamp_delay(cfg_delay);
         if (in_valid) begin
            fill_n  = DW'(1);
            state_n = (delay_n == DW'(1)) ? PRIMED : FILLING;
         end else begin
            fill_n  = '0;
            state_n = EMPTY;
         end
      end else if (in_valid) begin
         valid_n = (fill >= delay_act);
         fill_n  = fill_inc;
         state_n = (fill_inc >= delay_act) ? PRIMED : FILLING;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         fill      <= '0;
         wr_ptr    <= '0;
         delay_act <= DW'(DEPTH);
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_n;
         fill      <= fill_n;
         delay_act <= delay_n;
         out_valid <= valid_n;
         out_data  <= valid_n ? mem[rd_ptr] : '0;
         if (in_valid)
            wr_ptr <= wr_ptr_inc;
      end
   end

   // Storage is never reset; out_data gating hides unwritten entries.
   always_ff @(posedge clk) begin
      if (in_valid)
         mem[wr_ptr] <= in_data;
   end

   assign primed = (state == PRIMED);

`ifdef PARAM_DELAY_LINE_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         smp_count <= '0;
      else if (cfg_load)
         smp_count <= '0;
      else if (valid_n)
         smp_count <= smp_count + 16'd1;
   end
`else
   // No sample counter in this build.
`endif

endmodule

// File: tb/tb_param_delay_line.sv
// Directed self-checking bench for param_delay_line at WIDTH=8, DEPTH=16.
module tb_param_delay_line;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic [4:0] cfg_delay;
   logic       cfg_load;
   logic [7:0] out_data;
   logic       out_valid;
   logic       primed;
   logic [4:0] delay_act;
`ifdef PARAM_DELAY_LINE_COUNT_EN
   logic [15:0] smp_count;
`endif

   int checks   = 0;
   int failures = 0;

   param_delay_line #(.WIDTH(8), .DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .cfg_delay (cfg_delay),
      .cfg_load  (cfg_load),
      .out_data  (out_data),
      .out_valid (out_valid),
      .primed    (primed),
      .delay_act (delay_act)
`ifdef PARAM_DELAY_LINE_COUNT_EN
      ,
      .smp_count (smp_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
   task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic ld, input logic [4:0] cd);
      in_valid  = v;
      in_data   = d;
      cfg_load  = ld;
      cfg_delay = cd;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; in_data = '0; in_valid = 1'b0; cfg_delay = '0; cfg_load = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_out_data", 32'(out_data), 32'h0);
      check_output("rst_out_valid", 32'(out_valid), 32'h0);
      check_output("rst_primed", 32'(primed), 32'h0);
      check_output("rst_delay_act", 32'(delay_act), 32'd16);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // D=3, back-to-back samples 0x01..0x08
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd3);
      check_output("d3_delay_act", 32'(delay_act), 32'd3);
      check_output("d3_primed_empty", 32'(primed), 32'h0);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 8'(i + 1), 1'b0, 5'd0);
         check_output("d3_valid", 32'(out_valid), (i >= 3) ? 32'h1 : 32'h0);
         check_output("d3_data", 32'(out_data), (i >= 3) ? 32'(i - 2) : 32'h0);
         check_output("d3_primed", 32'(primed), (i >= 2) ? 32'h1 : 32'h0);
      end
      apply_stimulus(1'b0, 8'hEE, 1'b0, 5'd0);
      check_output("d3_idle_valid", 32'(out_valid), 32'h0);
      check_output("d3_idle_data", 32'(out_data), 32'h0);

      // D=DEPTH, samples every other cycle, pointer wraps several times
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd16);
      check_output("d16_delay_act", 32'(delay_act), 32'd16);
      for (int k = 0; k < 48; k++) begin
         apply_stimulus(1'b1, 8'(k), 1'b0, 5'd0);
         check_output("d16_valid", 32'(out_valid), (k >= 16) ? 32'h1 : 32'h0);
         check_output("d16_data", 32'(out_data), (k >= 16) ? 32'(k - 16) : 32'h0);
         apply_stimulus(1'b0, 8'hCC, 1'b0, 5'd0);
         check_output("d16_idle_valid", 32'(out_valid), 32'h0);
         check_output("d16_idle_data", 32'(out_data), 32'h0);
      end

      // Clamping and D=1
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd0);
      check_output("clamp_zero", 32'(delay_act), 32'd1);
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd20);
      check_output("clamp_high", 32'(delay_act), 32'd16);
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd0);
      apply_stimulus(1'b1, 8'hA5, 1'b0, 5'd0);
      check_output("d1_first_valid", 32'(out_valid), 32'h0);
      check_output("d1_primed", 32'(primed), 32'h1);
      apply_stimulus(1'b1, 8'h5A, 1'b0, 5'd0);
      check_output("d1_valid", 32'(out_valid), 32'h1);
      check_output("d1_data", 32'(out_data), 32'hA5);

      // Reload with a concurrent sample while primed at D=4
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd4);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'(8'h30 + i), 1'b0, 5'd0);
      check_output("d4_primed", 32'(primed), 32'h1);
      apply_stimulus(1'b1, 8'h77, 1'b1, 5'd2);
      check_output("reload_valid", 32'(out_valid), 32'h0);
      check_output("reload_delay_act", 32'(delay_act), 32'd2);
      check_output("reload_primed", 32'(primed), 32'h0);
      apply_stimulus(1'b1, 8'h78, 1'b0, 5'd0);
      check_output("reload_78_valid", 32'(out_valid), 32'h0);
      check_output("reload_78_primed", 32'(primed), 32'h1);
      apply_stimulus(1'b1, 8'h79, 1'b0, 5'd0);
      check_output("reload_79_valid", 32'(out_valid), 32'h1);
      check_output("reload_79_data", 32'(out_data), 32'h77);

      // Asynchronous reset mid-stream at D=5
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd5);
      for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 8'(8'h40 + i), 1'b0, 5'd0);
      check_output("pre_rst_data", 32'(out_data), 32'h40);
      #1 rst_n = 1'b0;
      #1;
      check_output("async_rst_valid", 32'(out_valid), 32'h0);
      check_output("async_rst_data", 32'(out_data), 32'h0);
      check_output("async_rst_primed", 32'(primed), 32'h0);
      check_output("async_rst_delay", 32'(delay_act), 32'd16);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(1'b1, 8'(8'h10 + i), 1'b0, 5'd0);
         check_output("post_rst_valid", 32'(out_valid), 32'h0);
         check_output("post_rst_data", 32'(out_data), 32'h0);
         check_output("post_rst_primed", 32'(primed), (i == 15) ? 32'h1 : 32'h0);
      end
      apply_stimulus(1'b1, 8'h20, 1'b0, 5'd0);
      check_output("post_rst_first_valid", 32'(out_valid), 32'h1);
      check_output("post_rst_first_data", 32'(out_data), 32'h10);

`ifdef PARAM_DELAY_LINE_COUNT_EN
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd2);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 5'd0);
      check_output("count_after_10", 32'(smp_count), 32'd8);
      apply_stimulus(1'b0, 8'h00, 1'b1, 5'd2);
      check_output("count_cleared", 32'(smp_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
